encoder_74148_seq: RTL and testbench

- Sequential counterpart to the team's 74138 decoder: a 74148-style 8-to-3 priority encoder with registered outputs.
- Eight asynchronous active-low request lines are synchronised and edge-detected, then latched into a pending register.
- The highest-priority pending request (line 7 highest) is presented as a 3-bit code and held stable until the consumer acknowledges it.
- Typical use: interrupt or event aggregation feeding a 74138-style select bus.

---
 rtl/encoder_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 31 +++
 rtl/encoder_74148_seq.sv | 94 +++++++++
 tb/tb_encoder_74148_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the sequential 74148-style priority encoder.
package encoder_pkg;

  localparam int NUM_REQ = 8;
  localparam int CODE_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Highest set index of an 8-bit vector; 0 when nothing is set.
  function automatic logic [CODE_W-1:0] prio_enc8(input logic [NUM_REQ-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser per request line followed by a falling-edge detector.
// All flops reset to 1 so that released lines read as inactive.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] in_n_i,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] hist_p;

  // Synchroniser chain plus one history stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '1;
      hist_p <= '1;
    end else begin
      sync_p[0] <= in_n_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      hist_p <= sync_p[SYNC_STAGES-1];
    end
  end

  // A line that was high last cycle and is low now has just been requested.
  assign fall_o = hist_p & ~sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/encoder_74148_seq.sv
// Registered 8-to-3 priority encoder: captured requests are latched as pending,
// the highest one is presented and held until the consumer acknowledges it.
module encoder_74148_seq
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ei_n_i,
  input  logic [NUM_REQ-1:0] in_n_i,
  input  logic              ack_i,
  output logic [CODE_W-1:0] a_n_o,
  output logic [CODE_W-1:0] code_o,
  output logic              gs_n_o,
  output logic              eo_n_o,
  output logic              valid_o,
  output logic [NUM_REQ-1:0] pending_o
);

  logic [NUM_REQ-1:0] fall;
  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] pending_nxt;
  logic [NUM_REQ-1:0] clr;
  state_t             state_q;
  state_t             state_nxt;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  code_nxt;
  logic [CODE_W-1:0]  a_n_q;
  logic               gs_n_q;
  logic               eo_n_q;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (NUM_REQ)
  ) u_sync_edge_det (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .in_n_i  (in_n_i),
    .fall_o  (fall)
  );

  // Next-state, code selection and pending update; a new edge beats a clear.
  always_comb begin
    state_nxt = state_q;
    code_nxt  = code_q;
    clr       = '0;
    case (state_q)
      IDLE: begin
        if (!ei_n_i && (pending_q != '0)) begin
          state_nxt = HOLD;
          code_nxt  = prio_enc8(pending_q);
        end
      end
      HOLD: begin
        if (ei_n_i) begin
          state_nxt = IDLE;
        end else if (ack_i) begin
          state_nxt    = IDLE;
          clr[code_q]  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pending_nxt = (pending_q & ~clr) | fall;
  end

  // State, pending register and outputs, all registered from the next state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      code_q    <= '0;
      pending_q <= '0;
      a_n_q     <= '1;
      gs_n_q    <= 1'b1;
      eo_n_q    <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      code_q    <= code_nxt;
      pending_q <= pending_nxt;
      a_n_q     <= (state_nxt == HOLD) ? ~code_nxt : '1;
      gs_n_q    <= (state_nxt != HOLD);
      eo_n_q    <= !(!ei_n_i && (state_nxt == IDLE) && (pending_nxt == '0));
    end
  end

  assign a_n_o     = a_n_q;
  assign code_o    = ~a_n_q;
  assign gs_n_o    = gs_n_q;
  assign valid_o   = ~gs_n_q;
  assign eo_n_o    = eo_n_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_encoder_74148_seq.sv
// Bench for encoder_74148_seq: directed scenarios with literal expectations,
// then random traffic, all compared each cycle against a behavioural model.
module tb_encoder_74148_seq;

  localparam int S = 2;

  logic       clk;
  logic       rst_n;
  logic       ei_n;
  logic [7:0] in_n;
  logic       ack;
  logic [2:0] a_n;
  logic [2:0] code;
  logic       gs_n;
  logic       eo_n;
  logic       valid;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  encoder_74148_seq #(.SYNC_STAGES(S)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .ei_n_i    (ei_n),
    .in_n_i    (in_n),
    .ack_i     (ack),
    .a_n_o     (a_n),
    .code_o    (code),
    .gs_n_o    (gs_n),
    .eo_n_o    (eo_n),
    .valid_o   (valid),
    .pending_o (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: requests seen S edges late, presented code as an
  // integer (-1 = nothing presented).
  logic [7:0] dl [S+1];
  int         m_code;
  logic [7:0] m_pend;
  logic       m_eo_n;

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= S; i++) dl[i] = 8'hFF;
      m_code = -1;
      m_pend = 8'h00;
      m_eo_n = 1'b1;
    end else begin
      logic [7:0] f;
      logic [7:0] np;
      int         nc;
      f  = dl[S] & ~dl[S-1];
      np = m_pend;
      nc = m_code;
      if (m_code >= 0) begin
        if (ei_n) nc = -1;
        else if (ack) begin
          np[m_code] = 1'b0;
          nc = -1;
        end
      end else if (!ei_n && m_pend != 0) begin
        nc = highest(m_pend);
      end
      np = np | f;
      m_eo_n = !(!ei_n && nc < 0 && np == 0);
      m_pend = np;
      m_code = nc;
      for (int i = S; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = in_n;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", valid, (m_code >= 0));
      chk("m_code", code, (m_code >= 0) ? m_code : 0);
      chk("m_a_n", a_n, (m_code >= 0) ? (7 - m_code) : 7);
      chk("m_gs_n", gs_n, (m_code >= 0) ? 0 : 1);
      chk("m_eo_n", eo_n, m_eo_n);
      chk("m_pending", pending, m_pend);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_n"}, a_n, 3'b111);
    chk({tag, "_code"}, code, 3'b000);
    chk({tag, "_gs_n"}, gs_n, 1);
    chk({tag, "_eo_n"}, eo_n, 1);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_pend"}, pending, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    ei_n  = 1'b0;
    in_n  = 8'hFF;
    ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    #3 rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_a_n", a_n, 3'b111);
    chk("idle_gs_n", gs_n, 1);
    chk("idle_eo_n", eo_n, 0);
    chk("idle_valid", valid, 0);
    chk("idle_pend", pending, 8'h00);

    // Single request on line 2.
    in_n = 8'hFB;
    repeat (3) tick();
    chk("b2_pend_e2", pending, 8'h04);
    chk("b2_valid_e2", valid, 0);
    tick();
    chk("b2_code", code, 2);
    chk("b2_a_n", a_n, 3'b101);
    chk("b2_gs_n", gs_n, 0);
    chk("b2_eo_n", eo_n, 1);
    in_n = 8'hFF;
    pulse_ack();
    chk("b2_ack_pend", pending, 8'h00);
    chk("b2_ack_valid", valid, 0);
    repeat (4) tick();

    // Lines 1 and 6 together.
    in_n = 8'hBD;
    repeat (4) tick();
    chk("b16_first", code, 6);
    in_n = 8'hFF;
    pulse_ack();
    chk("b16_gap", valid, 0);
    tick();
    chk("b16_second", code, 1);
    chk("b16_second_v", valid, 1);
    pulse_ack();
    chk("b16_eo_n", eo_n, 0);
    repeat (4) tick();

    // Hold 3, then line 7 arrives: code must stay 3.
    in_n = 8'hF7;
    repeat (4) tick();
    chk("h3_code", code, 3);
    in_n = 8'h7F;
    repeat (4) tick();
    chk("h3_pend", pending, 8'h88);
    chk("h3_hold", code, 3);
    in_n = 8'hFF;
    pulse_ack();
    tick();
    chk("h3_then7", code, 7);
    pulse_ack();
    repeat (4) tick();

    // Hold 5, drop enable, restore.
    in_n = 8'hDF;
    repeat (4) tick();
    chk("h5_code", code, 5);
    in_n = 8'hFF;
    ei_n = 1'b1;
    tick();
    chk("dis_a_n", a_n, 3'b111);
    chk("dis_gs_n", gs_n, 1);
    chk("dis_eo_n", eo_n, 1);
    chk("dis_pend", pending, 8'h20);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("dis_ack_pend", pending, 8'h20);
    ei_n = 1'b0;
    tick();
    chk("en_code", code, 5);
    chk("en_valid", valid, 1);

    // Asynchronous reset mid-hold.
    #3 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) tick();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) in_n[b] = ~in_n[b];
      ei_n = ($urandom_range(0, 15) == 0);
      ack  = ($urandom_range(0, 2) == 0);
      tick();
    end
    ack = 1'b0;
    ei_n = 1'b0;
    in_n = 8'hFF;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
